// File: rtl/awgn_channel.sv
// AWGN channel: adds gain-scaled Q7 noise to a Q7 symbol stream, saturates to 16 bits.
// Two-stage valid/ready pipeline. Define AWGN_NOISE_POWER_EN for per-frame noise energy output.
module awgn_channel #(
  parameter int FRAME_LEN = 64,
  parameter int GAIN_FRAC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] noise_i,
  input  logic [7:0]  noise_gain_i,
  input  logic        bypass_i,
  input  logic [15:0] sig_i,
  input  logic        sig_valid_i,
  output logic        sig_ready_o,
  output logic [15:0] out_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        out_last_o,
  output logic        sat_o,
  output logic [31:0] noise_pow_o,
  output logic        noise_pow_valid_o
);
  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

  logic [CW-1:0]      frame_cnt;
  logic [7:0]         g_lat;
  logic               s1_valid, s1_last;
  logic signed [15:0] s1_sig;
  logic signed [20:0] s1_ns;

  logic               adv1, adv2, accept, frame_start, cnt_last;
  logic [7:0]         g_cur;
  logic signed [24:0] prod;
  logic signed [20:0] ns_new;
  logic signed [21:0] sum;
  logic [15:0]        clip_val;
  logic               clip_sat;

  always_comb begin
    adv2        = !out_valid_o || out_ready_i;
    adv1        = !s1_valid || adv2;
    accept      = sig_valid_i && adv1;
    frame_start = (frame_cnt == '0);
    cnt_last    = (frame_cnt == LAST_CNT);
    // Gain is only sampled on the first sample of a frame.
    g_cur       = frame_start ? noise_gain_i : g_lat;
    prod        = 25'(signed'(noise_i)) * 25'(signed'({1'b0, g_cur}));
    ns_new      = bypass_i ? '0 : 21'(prod >>> GAIN_FRAC);
    sum         = 22'(s1_sig) + 22'(s1_ns);
    clip_sat    = 1'b0;
    clip_val    = sum[15:0];
    if (sum > 22'sd32767) begin
      clip_val = 16'h7FFF;
      clip_sat = 1'b1;
    end else if (sum < -22'sd32768) begin
      clip_val = 16'h8000;
      clip_sat = 1'b1;
    end
  end

  assign sig_ready_o = adv1;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt   <= '0;
      g_lat       <= '0;
      s1_valid    <= 1'b0;
      s1_last     <= 1'b0;
      s1_sig      <= '0;
      s1_ns       <= '0;
      out_o       <= '0;
      out_valid_o <= 1'b0;
      out_last_o  <= 1'b0;
      sat_o       <= 1'b0;
    end else begin
      if (adv1) s1_valid <= sig_valid_i;
      if (accept) begin
        s1_sig    <= signed'(sig_i);
        s1_ns     <= ns_new;
        s1_last   <= cnt_last;
        frame_cnt <= cnt_last ? '0 : frame_cnt + 1'b1;
        if (frame_start) g_lat <= noise_gain_i;
      end
      if (adv2) begin
        out_valid_o <= s1_valid;
        if (s1_valid) begin
          out_o      <= clip_val;
          sat_o      <= clip_sat;
          out_last_o <= s1_last;
        end
      end
    end
  end

`ifdef AWGN_NOISE_POWER_EN
  logic signed [41:0] sq;
  logic [31:0]        e_new, out_e, acc, acc_next;
  logic [32:0]        acc_sum;

  always_comb begin
    sq       = 42'(s1_ns) * 42'(s1_ns);
    e_new    = 32'(sq >>> 7);
    acc_sum  = {1'b0, acc} + {1'b0, out_e};
    acc_next = acc_sum[32] ? '1 : acc_sum[31:0];
  end

  // out_e tracks the energy of the sample currently held in the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_e             <= '0;
      acc               <= '0;
      noise_pow_o       <= '0;
      noise_pow_valid_o <= 1'b0;
    end else begin
      noise_pow_valid_o <= 1'b0;
      if (adv2 && s1_valid) out_e <= e_new;
      if (out_valid_o && out_ready_i) begin
        if (out_last_o) begin
          noise_pow_o       <= acc_next;
          noise_pow_valid_o <= 1'b1;
          acc               <= '0;
        end else begin
          acc <= acc_next;
        end
      end
    end
  end
`else
  assign noise_pow_o       = '0;
  assign noise_pow_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_awgn_channel.sv
// Self-checking bench for awgn_channel: directed single-sample vectors plus streamed
// sequences (gain latching, frame marks, backpressure, mid-frame reset, noise power).
module tb_awgn_channel;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] noise = '0;
  logic [7:0]  gain = '0;
  logic        bypass = 1'b0;
  logic [15:0] sig = '0;
  logic        sig_valid = 1'b0;
  logic        sig_ready;
  logic [15:0] out;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last, sat;
  logic [31:0] pow;
  logic        pow_valid;

  int checks = 0;
  int fails  = 0;

  awgn_channel #(.FRAME_LEN(64), .GAIN_FRAC(4)) dut (
    .clk(clk), .rst(rst), .noise_i(noise), .noise_gain_i(gain), .bypass_i(bypass),
    .sig_i(sig), .sig_valid_i(sig_valid), .sig_ready_o(sig_ready),
    .out_o(out), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_last_o(out_last), .sat_o(sat),
    .noise_pow_o(pow), .noise_pow_valid_o(pow_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sig;
    logic [15:0] noise;
    logic [7:0]  gain;
    logic        byp;
    logic [15:0] out;
    logic        sat;
  } vec_t;

  typedef struct {
    logic [15:0] out;
    logic        sat;
    logic        last;
    int          ns;
  } exp_t;

  vec_t        vt[11];
  logic [15:0] got_out[0:255];
  int          last_cnt, last_idx;
  logic [31:0] last_pow;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; sig_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // mode 0: gain change mid-frame, mode 1: random traffic, mode 2: constant noise/gain
  task automatic run_stream(input int n, input int mode);
    exp_t   q[$];
    exp_t   e;
    int     sent = 0, got = 0, mcnt = 0, cyc = 0, nv, ns, s;
    logic [7:0]  mg = '0;
    logic   acc_now = 1'b0, hold_pend = 1'b0;
    logic [15:0] hold_val = '0;
    longint pacc = 0;
    logic   pexp_v = 1'b0;
    longint pexp_val = 0;
    last_cnt = 0; last_idx = -1; last_pow = '0;
    while (got < n && cyc < 5000) begin
      if (!sig_valid || acc_now) begin
        if (sent < n && (mode != 1 || $urandom_range(3) != 0)) begin
          sig_valid = 1'b1;
          case (mode)
            0: begin sig = '0; gain = (sent < 10) ? 8'h10 : 8'h30; bypass = 1'b0; end
            1: begin sig = 16'($urandom); gain = 8'($urandom); bypass = ($urandom_range(7) == 0); end
            default: begin sig = '0; gain = 8'h10; bypass = 1'b0; end
          endcase
        end else sig_valid = 1'b0;
      end
      noise     = (mode == 1) ? 16'($urandom) : 16'h0080;
      out_ready = (mode == 1) ? 1'($urandom_range(1)) : 1'b1;
      @(negedge clk);
      cyc++;
`ifdef AWGN_NOISE_POWER_EN
      chk("pow_strobe", pow_valid, pexp_v);
      if (pexp_v) begin
        chk("pow_value", pow, pexp_val);
        last_pow = pow;
      end
      pexp_v = 1'b0;
`else
      chk("pow_tied0", {pow, pow_valid}, 0);
`endif
      if (hold_pend) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_out", out, hold_val);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          e = q.pop_front();
          chk("stream_out", out, e.out);
          chk("stream_sat", sat, e.sat);
          chk("stream_last", out_last, e.last);
          if (got < 256) got_out[got] = out;
          if (out_last) begin last_cnt++; last_idx = got; end
`ifdef AWGN_NOISE_POWER_EN
          pacc = pacc + ((longint'(e.ns) * e.ns) >>> 7);
          if (pacc > 64'hFFFF_FFFF) pacc = 64'hFFFF_FFFF;
          if (e.last) begin pexp_v = 1'b1; pexp_val = pacc; pacc = 0; end
`endif
        end
        got++;
      end
      hold_pend = out_valid && !out_ready;
      hold_val  = out;
      acc_now   = sig_valid && sig_ready;
      if (acc_now) begin
        if (mcnt == 0) mg = gain;
        nv = 32'($signed(noise));
        ns = bypass ? 0 : (nv * int'(mg)) >>> 4;
        s  = nv * 0 + 32'($signed(sig)) + ns;
        e.sat  = (s > 32767) || (s < -32768);
        e.out  = (s > 32767) ? 16'h7FFF : (s < -32768) ? 16'h8000 : s[15:0];
        e.last = (mcnt == 63);
        e.ns   = ns;
        mcnt   = (mcnt == 63) ? 0 : mcnt + 1;
        q.push_back(e);
        sent++;
      end
      @(posedge clk); #1;
    end
    sig_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", got, n);
    chk("stream_leftover", q.size(), 0);
`ifdef AWGN_NOISE_POWER_EN
    @(negedge clk);
    chk("pow_strobe_end", pow_valid, pexp_v);
    if (pexp_v) begin
      chk("pow_value_end", pow, pexp_val);
      last_pow = pow;
    end
`endif
  endtask

  initial begin
    //            sig       noise     gain   byp   out       sat
    vt[0]  = '{16'h0100, 16'h0080, 8'h10, 1'b0, 16'h0180, 1'b0};
    vt[1]  = '{16'h7F00, 16'h0200, 8'h20, 1'b0, 16'h7FFF, 1'b1};
    vt[2]  = '{16'h8100, 16'hFE00, 8'h20, 1'b0, 16'h8000, 1'b1};
    vt[3]  = '{16'h1234, 16'h7FFF, 8'h00, 1'b0, 16'h1234, 1'b0};
    vt[4]  = '{16'h0100, 16'h7FFF, 8'hFF, 1'b1, 16'h0100, 1'b0};
    vt[5]  = '{16'h0010, 16'hFFFF, 8'h01, 1'b0, 16'h000F, 1'b0};
    vt[6]  = '{16'h0010, 16'h0001, 8'h01, 1'b0, 16'h0010, 1'b0};
    vt[7]  = '{16'h0000, 16'h8000, 8'hFF, 1'b0, 16'h8000, 1'b1};
    vt[8]  = '{16'h7E00, 16'h0100, 8'h18, 1'b0, 16'h7F80, 1'b0};
    vt[9]  = '{16'h7F00, 16'h00FF, 8'h10, 1'b0, 16'h7FFF, 1'b0};
    vt[10] = '{16'h8000, 16'hFFFF, 8'h10, 1'b0, 16'h8000, 1'b1};

    do_reset();
    @(negedge clk);
    chk("reset_outs", {out, out_valid, out_last, sat}, 0);
    chk("reset_pow", {pow, pow_valid}, 0);
    chk("reset_ready", sig_ready, 1);

    foreach (vt[i]) begin
      do_reset();
      sig = vt[i].sig; noise = vt[i].noise; gain = vt[i].gain; bypass = vt[i].byp;
      sig_valid = 1'b1;
      @(negedge clk);
      chk("vec_ready", sig_ready, 1);
      @(posedge clk); #1;
      sig_valid = 1'b0; noise = 16'h5A5A; gain = 8'h77; bypass = ~vt[i].byp;
      @(negedge clk);
      chk("vec_lat1", out_valid, 0);
      @(negedge clk);
      chk("vec_valid", out_valid, 1);
      chk("vec_out", out, vt[i].out);
      chk("vec_sat", sat, vt[i].sat);
    end

    // Gain changed mid-frame only takes effect at the next frame.
    do_reset();
    run_stream(130, 0);
    chk("gain_mid_frame", got_out[20], 16'h0080);
    chk("gain_next_frame", got_out[64], 16'h0180);
    chk("last_count", last_cnt, 2);
    chk("last_idx", last_idx, 127);

    // Random backpressure and source gaps.
    do_reset();
    run_stream(200, 1);

    // Reset asserted mid-frame with a full pipe.
    do_reset();
    sig = 16'h0040; noise = 16'h0080; gain = 8'h10; bypass = 1'b0; sig_valid = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1; sig_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_outs", {out, out_valid, out_last, sat}, 0);
    chk("midrst_pow", {pow, pow_valid}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_stream(64, 2);
    chk("midrst_last_idx", last_idx, 63);
    chk("midrst_last_cnt", last_cnt, 1);

    // Constant noise 1.0 at gain 1.0 -> 64 * 128 per frame.
    do_reset();
    run_stream(128, 2);
`ifdef AWGN_NOISE_POWER_EN
    chk("pow_8192", last_pow, 32'd8192);
`else
    chk("pow_disabled", {pow, pow_valid}, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
